uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Parametrised N-source byte-stream arbiter in front of uart_tx. Replaces per-mode print muxing:
//   print sources (input echo, generate, display table, calculate result) raise frames of bytes; one
//   source is granted per whole frame (round-robin), bytes are buffered in a FIFO and paced into uart_tx.
// PARAMETERS
//   NUM_SRC     4    number of byte-stream sources (1..8)
//   DATA_W      8    byte width
//   FIFO_DEPTH  16   output FIFO entries, power of 2, >=2
//   BUSY_TO     8    cycles to wait for uart_tx_busy to rise after a tx pulse before proceeding
// PORTS
//   clk           in   1                 system clock; single clock domain
//   rst           in   1                 synchronous, active-high reset
//   src_en        in   NUM_SRC           per-source enable (mode enables); 0 = source ignored
//   src_valid     in   NUM_SRC           byte present on src_data slice i
//   src_last      in   NUM_SRC           qualifies src_valid: this byte ends the frame
//   src_data      in   NUM_SRC*DATA_W    source i at [i*DATA_W +: DATA_W]
//   src_ready     out  NUM_SRC           byte accepted when src_valid[i] & src_ready[i]
//   uart_tx_busy  in   1                 from uart_tx
//   uart_tx_en    out  1                 one-cycle launch pulse to uart_tx
//   uart_tx_data  out  DATA_W            byte for uart_tx, stable from pulse until next pulse
//   grant_valid   out  1                 a source currently owns the FIFO input
//   grant_id      out  $clog2(NUM_SRC)   owning source index (0 when NUM_SRC=1)
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  bytes buffered
//   frame_abort   out  1                 one-cycle pulse: granted source dropped src_en mid-frame
//   busy          out  1                 grant_valid | fifo_level!=0 | tx in flight
// BEHAVIOUR
//   Reset: all outputs 0; FIFO empty; RR pointer = 0; TX FSM in T_IDLE.
//   Arbiter (registered grant):
//   - No grant: candidates = src_en & src_valid. Pick first candidate at or after RR pointer (wrapping).
//     grant_valid/grant_id update on the next edge; no byte accepted in the selecting cycle.
//   - src_ready[i] = grant_valid & grant_id==i & src_en[i] & fifo not full; all others 0 (combinational).
//   - Accepted byte with src_last=1: grant released next edge, RR pointer = grant_id+1 mod NUM_SRC.
//   - Granted source with src_en=0: grant released next edge, frame_abort pulses 1 cycle, RR pointer
//     advances; bytes already in FIFO still drain. No abort when released by src_last.
//   - Frames never interleave in the FIFO.
//   FIFO: circular, wr/rd pointers wrap at FIFO_DEPTH. Full => src_ready=0. Simultaneous write and
//   read when full or empty is legal; fifo_level unchanged for full-with-read+write.
//   TX FSM:
//   - T_IDLE: FIFO non-empty & !uart_tx_busy -> pop head, drive uart_tx_data, uart_tx_en=1 for one
//     cycle, -> T_WAIT_HI (cnt=0).
//   - T_WAIT_HI: busy=1 -> T_WAIT_LO; else cnt++, cnt==BUSY_TO-1 -> T_IDLE (tolerates fast/no-busy tx).
//   - T_WAIT_LO: busy=0 -> T_IDLE.
//   - Minimum 2 cycles between uart_tx_en pulses; at most one pulse per byte; byte order preserved.
//   Reset mid-operation: FIFO flushed, grant dropped, no further uart_tx_en, byte in flight not retried.
//   src_valid without src_en is ignored and never granted. NUM_SRC=1: grant_id tied 0, arbitration trivial.
// TESTING
//   1 Single frame: src0 sends "1 2\n" (4 bytes, last on '\n'), busy model 10 cycles -> 4 tx pulses,
//     same order, >=2 cycles apart, grant released after '\n', fifo_level returns 0.
//   2 Contention: src1 and src3 request together, RR=0 -> src1 frame fully, then src3; next tie
//     src1/src3 again with RR=2 -> src3 first.
//   3 Backpressure: FIFO_DEPTH=4, busy held high 200 cycles, src0 sends 10 bytes -> src_ready low at
//     fifo_level=4, no byte lost or duplicated once busy drops.
//   4 Abort: src2 granted, drop src_en[2] after 3 bytes -> frame_abort one pulse, 3 bytes still sent,
//     src0 then granted.
//   5 No-busy tx: uart_tx_busy tied 0 -> pulses spaced BUSY_TO+1 cycles, all bytes delivered.
//   6 Reset mid-frame with 5 bytes buffered -> outputs 0 next cycle, no uart_tx_en after reset.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream source bus for uart_tx_arbiter: one valid/last/data lane per source plus a ready vector.
interface uart_tx_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_last;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;

    modport master (output src_en, src_valid, src_last, src_data, input src_ready);
    modport slave  (input src_en, src_valid, src_last, src_data, output src_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-granular arbiter of N byte sources into a FIFO, paced out to uart_tx.
// state     | meaning
// T_IDLE    | waiting for a buffered byte and uart_tx not busy
// T_WAIT_HI | byte launched, waiting up to BUSY_TO cycles for busy to rise
// T_WAIT_LO | uart_tx busy, waiting for it to finish
module uart_tx_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BUSY_TO    = 8,
    localparam int ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_arbiter_if.slave    src,
    input  logic                uart_tx_busy,
    output logic                uart_tx_en,
    output logic [DATA_W-1:0]   uart_tx_data,
    output logic                grant_valid,
    output logic [ID_W-1:0]     grant_id,
    output logic [AW:0]         fifo_level,
    output logic                frame_abort,
    output logic                busy
);
    typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} tx_state_t;

    tx_state_t          tx_state, tx_state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ID_W-1:0]    rr_ptr, pick_id, next_id, idx;
    logic [NUM_SRC-1:0] cand;
    logic               fifo_full, fifo_empty, wr_en, rd_en;
    logic               src_en_g, src_valid_g, src_last_g;
    logic [DATA_W-1:0]  wr_data;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;

    assign cand = src.src_en & src.src_valid;

    // Scan from the highest offset down so the first candidate at/after rr_ptr wins.
    always_comb begin
        pick_id = '0;
        idx     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (cand[idx]) pick_id = idx;
        end
    end

    always_comb begin
        src.src_ready = '0;
        wr_data       = '0;
        src_en_g      = 1'b0;
        src_valid_g   = 1'b0;
        src_last_g    = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == ID_W'(i)) begin
                wr_data          = src.src_data[i*DATA_W +: DATA_W];
                src_en_g         = src.src_en[i];
                src_valid_g      = src.src_valid[i];
                src_last_g       = src.src_last[i];
                src.src_ready[i] = grant_valid & src.src_en[i] & ~fifo_full;
            end
        end
    end

    assign wr_en   = grant_valid & src_en_g & src_valid_g & ~fifo_full;
    assign next_id = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            frame_abort <= 1'b0;
        end else begin
            frame_abort <= 1'b0;
            if (!grant_valid) begin
                if (|cand) begin
                    grant_valid <= 1'b1;
                    grant_id    <= pick_id;
                end
            end else if (!src_en_g) begin
                grant_valid <= 1'b0;
                frame_abort <= 1'b1;
                rr_ptr      <= next_id;
            end else if (wr_en && src_last_g) begin
                grant_valid <= 1'b0;
                rr_ptr      <= next_id;
            end
        end
    end

    assign fifo_full  = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= T_IDLE;
            cnt          <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            tx_state   <= tx_state_nxt;
            cnt        <= cnt_nxt;
            uart_tx_en <= rd_en;
            if (rd_en) uart_tx_data <= mem[rd_ptr];
        end
    end

    // A missing busy response times out after BUSY_TO cycles so a fast uart_tx cannot stall us.
    always_comb begin
        tx_state_nxt = tx_state;
        cnt_nxt      = cnt;
        rd_en        = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!fifo_empty && !uart_tx_busy) begin
                    rd_en        = 1'b1;
                    cnt_nxt      = '0;
                    tx_state_nxt = T_WAIT_HI;
                end
            end
            T_WAIT_HI: begin
                if (uart_tx_busy)                        tx_state_nxt = T_WAIT_LO;
                else if (cnt == CNT_W'(BUSY_TO - 1))     tx_state_nxt = T_IDLE;
                else                                     cnt_nxt      = cnt + 1'b1;
            end
            T_WAIT_LO: begin
                if (!uart_tx_busy) tx_state_nxt = T_IDLE;
            end
            default: tx_state_nxt = T_IDLE;
        endcase
    end

    assign busy = grant_valid | ~fifo_empty | (tx_state != T_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: dut_a (16-deep FIFO) for most scenarios, dut_b (4-deep) for backpressure.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int BT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) ifa ();
    uart_tx_arbiter_if #(.NUM_SRC(NS), .DATA_W(DW)) ifb ();

    logic       ubusy_a, txen_a, gv_a, abort_a, busy_a;
    logic [7:0] data_a;
    logic [1:0] gid_a;
    logic [4:0] lvl_a;
    logic       ubusy_b, txen_b, gv_b, abort_b, busy_b;
    logic [7:0] data_b;
    logic [1:0] gid_b;
    logic [2:0] lvl_b;

    uart_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(16), .BUSY_TO(BT)) dut_a (
        .clk(clk), .rst(rst), .src(ifa), .uart_tx_busy(ubusy_a), .uart_tx_en(txen_a),
        .uart_tx_data(data_a), .grant_valid(gv_a), .grant_id(gid_a), .fifo_level(lvl_a),
        .frame_abort(abort_a), .busy(busy_a));

    uart_tx_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(4), .BUSY_TO(BT)) dut_b (
        .clk(clk), .rst(rst), .src(ifb), .uart_tx_busy(ubusy_b), .uart_tx_en(txen_b),
        .uart_tx_data(data_b), .grant_valid(gv_b), .grant_id(gid_b), .fifo_level(lvl_b),
        .frame_abort(abort_b), .busy(busy_b));

    // uart_tx stand-ins: busy rises the cycle after a pulse for busy_len cycles
    int   busy_len_a = 10, busy_len_b = 10;
    int   bcnt_a = 0, bcnt_b = 0;
    logic force_b = 1'b0;
    always @(posedge clk) begin
        if (rst)         bcnt_a <= 0;
        else if (txen_a) bcnt_a <= busy_len_a;
        else if (bcnt_a > 0) bcnt_a <= bcnt_a - 1;
    end
    always @(posedge clk) begin
        if (rst)         bcnt_b <= 0;
        else if (txen_b) bcnt_b <= busy_len_b;
        else if (bcnt_b > 0) bcnt_b <= bcnt_b - 1;
    end
    assign ubusy_a = (bcnt_a != 0);
    assign ubusy_b = force_b | (bcnt_b != 0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // feed[k]: k=0..3 sources of dut_a, k=4..7 sources of dut_b; entry = {last, byte}
    logic [8:0] feed [8][$];
    int         abort_after [8];
    int         acc_cnt [8];
    logic [7:0] abort_done;
    logic [7:0] acc_pend;
    logic [3:0] sen_a = '0, sen_b = '0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    initial begin : driver
        logic [3:0]  va, la, vb, lb;
        logic [31:0] da, db;
        logic [8:0]  hd;
        abort_done = '0;
        acc_pend   = '0;
        for (int k = 0; k < 8; k++) begin
            acc_cnt[k]     = 0;
            abort_after[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (rst) begin
                abort_done = '0;
                acc_pend   = '0;
                for (int k = 0; k < 8; k++) acc_cnt[k] = 0;
            end
            for (int k = 0; k < 8; k++) begin
                if (acc_pend[k] && feed[k].size() > 0) begin
                    void'(feed[k].pop_front());
                    acc_cnt[k]++;
                    if (abort_after[k] != 0 && acc_cnt[k] == abort_after[k]) begin
                        abort_done[k] = 1'b1;
                        feed[k].delete();
                    end
                end
            end
            va = '0; la = '0; da = '0; vb = '0; lb = '0; db = '0;
            for (int s = 0; s < 4; s++) begin
                if (feed[s].size() > 0) begin
                    hd = feed[s][0];
                    va[s] = 1'b1; la[s] = hd[8]; da[s*8 +: 8] = hd[7:0];
                end
                if (feed[s+4].size() > 0) begin
                    hd = feed[s+4][0];
                    vb[s] = 1'b1; lb[s] = hd[8]; db[s*8 +: 8] = hd[7:0];
                end
            end
            ifa.src_valid = va; ifa.src_last = la; ifa.src_data = da;
            ifa.src_en    = sen_a & ~abort_done[3:0];
            ifb.src_valid = vb; ifb.src_last = lb; ifb.src_data = db;
            ifb.src_en    = sen_b & ~abort_done[7:4];
            #1;
            acc_pend = {ifb.src_valid & ifb.src_ready, ifa.src_valid & ifa.src_ready};
        end
    end

    int last_a = -1, last_b = -1, gap_a = 0;
    int pulses_a = 0, pulses_b = 0, aborts_a = 0, arun_a = 0, rdy3_a = 0, g3_a = 0;

    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (rst) begin
                last_a = -1;
                arun_a = 0;
            end else begin
                if (txen_a) begin
                    pulses_a++;
                    if (exp_a.size() == 0) check("a_tx_unexpected", {24'h0, data_a}, 32'h100);
                    else                   check("a_tx_byte", {24'h0, data_a}, {24'h0, exp_a.pop_front()});
                    if (last_a >= 0) begin
                        check("a_tx_min_gap", 32'((cyc - last_a) >= 2), 1);
                        if (gap_a != 0) check("a_tx_gap", cyc - last_a, gap_a);
                    end
                    last_a = cyc;
                end
                if (abort_a) arun_a++;
                else begin
                    if (arun_a > 0) begin
                        aborts_a++;
                        check("a_abort_width", arun_a, 1);
                    end
                    arun_a = 0;
                end
                if (ifa.src_ready[3]) rdy3_a++;
                if (gv_a && gid_a == 2'd3) g3_a++;
            end
        end
    end

    initial begin : mon_b
        forever begin
            @(negedge clk);
            if (rst) last_b = -1;
            else if (txen_b) begin
                pulses_b++;
                if (exp_b.size() == 0) check("b_tx_unexpected", {24'h0, data_b}, 32'h100);
                else                   check("b_tx_byte", {24'h0, data_b}, {24'h0, exp_b.pop_front()});
                if (last_b >= 0) check("b_tx_min_gap", 32'((cyc - last_b) >= 2), 1);
                last_b = cyc;
            end
        end
    end

    function automatic bit feeds_empty(input int d);
        for (int s = 0; s < 4; s++) if (feed[d*4 + s].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_byte(input int k, input logic [7:0] b, input logic last);
        feed[k].push_back({last, b});
    endtask

    // Frame of n bytes base, base+1, ...; the first n_exp are expected on the uart side.
    task automatic frame(input int k, input logic [7:0] base, input int n, input int n_exp);
        for (int i = 0; i < n; i++) push_byte(k, base + 8'(i), i == n - 1);
        for (int i = 0; i < n_exp; i++) begin
            if (k < 4) exp_a.push_back(base + 8'(i));
            else       exp_b.push_back(base + 8'(i));
        end
    endtask

    task automatic wait_idle_a(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(exp_a.size() == 0 && !busy_a && feeds_empty(0))) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_left"}, exp_a.size(), 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_level"}, lvl_a, 0);
    endtask

    task automatic wait_idle_b(input string tag, input int budget);
        int n = 0;
        while (n < budget && !(exp_b.size() == 0 && !busy_b && feeds_empty(1))) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_left"}, exp_b.size(), 0);
        check({tag, "_busy"}, busy_b, 0);
        check({tag, "_level"}, lvl_b, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        sen_a = '0;
        sen_b = '0;
        for (int k = 0; k < 8; k++) begin
            feed[k].delete();
            abort_after[k] = 0;
        end
        exp_a.delete();
        exp_b.delete();
        gap_a = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    logic [7:0] t1 [4] = '{8'h31, 8'h20, 8'h32, 8'h0a};
    int base_cnt;

    initial begin : stim
        int n;
        do_reset();
        // reset state
        check("rst_grant_valid", gv_a, 0);
        check("rst_grant_id", gid_a, 0);
        check("rst_level", lvl_a, 0);
        check("rst_tx_en", txen_a, 0);
        check("rst_tx_data", data_a, 0);
        check("rst_abort", abort_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", ifa.src_ready, 0);
        check("rst_b_level", lvl_b, 0);

        // single frame "1 2\n"; src3 has data but is disabled
        sen_a = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            push_byte(0, t1[i], i == 3);
            exp_a.push_back(t1[i]);
        end
        push_byte(3, 8'hEE, 1'b1);
        base_cnt = pulses_a;
        n = 0;
        while (n < 400 && !(exp_a.size() == 0 && !busy_a && feed[0].size() == 0)) begin
            @(negedge clk);
            n++;
        end
        check("t1_left", exp_a.size(), 0);
        check("t1_grant_released", gv_a, 0);
        check("t1_level", lvl_a, 0);
        check("t1_pulses", pulses_a - base_cnt, 4);
        check("t1_disabled_src_ready", rdy3_a, 0);
        check("t1_disabled_src_granted", g3_a, 0);
        check("t1_disabled_src_pending", feed[3].size(), 1);

        // contention: tie at RR=0 -> src1 first; lone src1 moves RR to 2; tie again -> src3 first
        do_reset();
        sen_a = 4'b1010;
        frame(1, 8'hA0, 3, 3);
        frame(3, 8'hC0, 4, 4);
        wait_idle_a("t2a", 600);
        frame(1, 8'hB0, 2, 2);
        wait_idle_a("t2b", 400);
        frame(3, 8'hD0, 2, 2);
        frame(1, 8'hE0, 3, 3);
        wait_idle_a("t2c", 600);
        check("t2_no_abort", aborts_a, 0);

        // backpressure on the 4-deep instance
        do_reset();
        force_b = 1'b1;
        sen_b   = 4'b0001;
        frame(4, 8'h50, 10, 10);
        repeat (30) @(negedge clk);
        check("t3_level_full", lvl_b, 4);
        check("t3_ready_low", ifb.src_ready[0], 0);
        check("t3_nothing_sent", exp_b.size(), 10);
        check("t3_src_remaining", feed[4].size(), 6);
        repeat (170) @(negedge clk);
        force_b = 1'b0;
        wait_idle_b("t3", 600);
        check("t3_pulses", pulses_b, 10);

        // abort: src2 drops enable after 3 accepted bytes, then src0 frame
        do_reset();
        base_cnt = aborts_a;
        sen_a = 4'b0101;
        abort_after[2] = 3;
        frame(2, 8'h70, 6, 3);
        repeat (4) @(negedge clk);
        frame(0, 8'h10, 2, 2);
        wait_idle_a("t4", 600);
        check("t4_abort_pulses", aborts_a - base_cnt, 1);

        // uart_tx never raises busy: pulses spaced BUSY_TO+1
        do_reset();
        busy_len_a = 0;
        gap_a      = BT + 1;
        sen_a      = 4'b0001;
        base_cnt   = pulses_a;
        frame(0, 8'h20, 5, 5);
        wait_idle_a("t5", 400);
        check("t5_pulses", pulses_a - base_cnt, 5);
        gap_a      = 0;

        // reset with 5 bytes buffered
        do_reset();
        busy_len_a = 40;
        sen_a      = 4'b0001;
        frame(0, 8'h40, 6, 6);
        n = 0;
        while (n < 60 && lvl_a != 5) begin
            @(negedge clk);
            n++;
        end
        check("t6_level5", lvl_a, 5);
        @(negedge clk);
        rst = 1'b1;
        exp_a.delete();
        feed[0].delete();
        @(negedge clk);
        check("t6_grant_valid", gv_a, 0);
        check("t6_level", lvl_a, 0);
        check("t6_tx_en", txen_a, 0);
        check("t6_tx_data", data_a, 0);
        check("t6_busy", busy_a, 0);
        check("t6_abort", abort_a, 0);
        rst = 1'b0;
        base_cnt = pulses_a;
        repeat (80) @(negedge clk);
        check("t6_no_tx_after_reset", pulses_a - base_cnt, 0);
        check("t6_idle", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
